// File: rtl/rtype_issue_seq.sv
// rtype_issue_seq: issue sequencer for RV32 R-type instructions.
// Decodes an offered instruction word and reads its two source operands
// from a 32x32 register file. It then presents funct7/funct3/rs1/rs2 to an
// external R-type ALU, waits ALU_LATENCY edges, and writes the result back
// to rd.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   instr_valid/ready   instruction handshake (ready only in IDLE w/o ext_we)
//   instr               RV32 instruction word
//   funct7/funct3       latched function fields to the ALU
//   rs1/rs2             latched operand values to the ALU
//   alu_result          ALU result, sampled on the last EXEC edge
//   ext_we/addr/data    register-file preload port (honoured in IDLE only)
//   dbg_addr/dbg_data   combinational register-file read
//   done                one-cycle pulse during writeback
//   illegal             one-cycle pulse after a rejected instruction
//
// Build option: define RTYPE_ISSUE_STRICT_EN to also reject R-type encodings
// other than funct7==0, or funct7==0100000 with funct3 of 0 (sub) or 5 (sra).
module rtype_issue_seq #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [6:0]  funct7,
    output logic [2:0]  funct3,
    output logic [31:0] rs1,
    output logic [31:0] rs2,
    input  logic [31:0] alu_result,
    input  logic        ext_we,
    input  logic [4:0]  ext_addr,
    input  logic [31:0] ext_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    localparam logic [1:0] CNT_LAST = 2'(ALU_LATENCY - 1);

    state_t      state, state_n;
    logic [1:0]  cnt;
    logic [4:0]  rd_q;
    logic [31:0] res_q;
    logic [31:0] regs [32];

    logic        hs;
    logic        legal;
    logic [31:0] src1_val, src2_val;

    assign instr_ready = (state == IDLE) && !ext_we;
    assign hs          = instr_valid && instr_ready;
    assign done        = (state == WB);

`ifdef RTYPE_ISSUE_STRICT_EN
    assign legal = (instr[6:0] == 7'b0110011) &&
                   ((instr[31:25] == 7'b0000000) ||
                    ((instr[31:25] == 7'b0100000) &&
                     ((instr[14:12] == 3'd0) || (instr[14:12] == 3'd5))));
`else
    assign legal = (instr[6:0] == 7'b0110011);
`endif

    // x0 is never written, but the explicit zero keeps reads correct even
    // if a stray value ever reached regs[0].
    always_comb begin
        src1_val = (instr[19:15] == 5'd0) ? 32'd0 : regs[instr[19:15]];
        src2_val = (instr[24:20] == 5'd0) ? 32'd0 : regs[instr[24:20]];
        dbg_data = (dbg_addr == 5'd0)     ? 32'd0 : regs[dbg_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (hs && legal) state_n = EXEC;
            EXEC:    if (cnt == CNT_LAST) state_n = WB;
            WB:      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ALU-facing fields change only on an accepted instruction, so they hold
    // from the cycle after the handshake until the next accepted one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            funct7  <= '0;
            funct3  <= '0;
            rs1     <= '0;
            rs2     <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            illegal <= 1'b0;
        end else begin
            illegal <= hs && !legal;
            if (hs && legal) begin
                funct7 <= instr[31:25];
                funct3 <= instr[14:12];
                rd_q   <= instr[11:7];
                rs1    <= src1_val;
                rs2    <= src2_val;
                cnt    <= '0;
            end
            if (state == EXEC) begin
                if (cnt == CNT_LAST) begin
                    res_q <= alu_result;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

    // Preload and writeback never collide: preload only in IDLE, writeback
    // only in WB. Back-to-back dependencies see the written value because
    // the next handshake can occur no earlier than the edge after WB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if ((state == IDLE) && ext_we) begin
            if (ext_addr != 5'd0) regs[ext_addr] <= ext_data;
        end else if (state == WB) begin
            if (rd_q != 5'd0) regs[rd_q] <= res_q;
        end
    end

endmodule

// File: tb/tb_rtype_issue_seq.sv
module tb_rtype_issue_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic [31:0] alu_result;
    logic        ext_we = 1'b0;
    logic [4:0]  ext_addr = '0;
    logic [31:0] ext_data = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        done, illegal;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rtype_issue_seq #(.ALU_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .funct7(funct7), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .alu_result(alu_result),
        .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .done(done), .illegal(illegal)
    );

    // Simple combinational R-type ALU standing in for the real one.
    always_comb begin
        case (funct3)
            3'd0:    alu_result = funct7[5] ? rs1 - rs2 : rs1 + rs2;
            3'd1:    alu_result = rs1 << rs2[4:0];
            3'd5:    alu_result = funct7[5] ? 32'($signed(rs1) >>> rs2[4:0]) : rs1 >> rs2[4:0];
            3'd7:    alu_result = rs1 & rs2;
            default: alu_result = rs1 ^ rs2;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] s2,
                                       input logic [4:0] s1, input logic [2:0] f3,
                                       input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        ext_we = 1'b1; ext_addr = a; ext_data = d;
        @(negedge clk);
        ext_we = 1'b0;
    endtask

    task automatic read_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1 chk(tag, dbg_data, exp);
    endtask

    // Offer at the current negedge; returns after the handshake edge, at the
    // following negedge, with instr_valid dropped.
    task automatic handshake(input logic [31:0] w);
        bit ok = 0;
        instr = w; instr_valid = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            #1;
            if (instr_ready) ok = 1;
            @(posedge clk);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_rtype(input string tag, input logic [31:0] w,
                             input logic [31:0] e_rs1, input logic [31:0] e_rs2,
                             input logic [31:0] e_res);
        handshake(w);
        chk({tag, "_f7"},   32'(funct7), 32'(w[31:25]));
        chk({tag, "_f3"},   32'(funct3), 32'(w[14:12]));
        chk({tag, "_rs1"},  rs1, e_rs1);
        chk({tag, "_rs2"},  rs2, e_rs2);
        chk({tag, "_rdy_exec"}, 32'(instr_ready), 32'd0);
        chk({tag, "_done_exec"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({tag, "_done_wb"}, 32'(done), 32'd1);
        chk({tag, "_rdy_wb"}, 32'(instr_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_done_after"}, 32'(done), 32'd0);
        chk({tag, "_rdy_idle"}, 32'(instr_ready), 32'd1);
        read_reg({tag, "_rd"}, w[11:7], e_res);
    endtask

    task automatic run_illegal(input string tag, input logic [31:0] w);
        logic [6:0] f7_before;
        f7_before = funct7;
        handshake(w);
        chk({tag, "_ill"}, 32'(illegal), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rdy"}, 32'(instr_ready), 32'd1);
        chk({tag, "_f7_hold"}, 32'(funct7), 32'(f7_before));
        @(negedge clk);
        chk({tag, "_ill_once"}, 32'(illegal), 32'd0);
        chk({tag, "_done2"}, 32'(done), 32'd0);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_f7", 32'(funct7), 32'd0);
        chk("rst_rs1", rs1, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ill", 32'(illegal), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);

        preload(5'd1, 32'd10);
        preload(5'd2, 32'd5);
        read_reg("pre_x1", 5'd1, 32'd10);

        // add x3,x1,x2
        run_rtype("add", rt(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd10, 32'd5, 32'd15);
        // back-to-back dependent add x8,x3,x3
        run_rtype("dep", rt(7'h00, 5'd3, 5'd3, 3'd0, 5'd8), 32'd15, 32'd15, 32'd30);
        // sub x4,x1,x2
        run_rtype("sub", rt(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), 32'd10, 32'd5, 32'd5);
        // sra x5,x6,x7
        preload(5'd6, 32'hF000_0000);
        preload(5'd7, 32'd4);
        run_rtype("sra", rt(7'h20, 5'd7, 5'd6, 3'd5, 5'd5), 32'hF000_0000, 32'd4, 32'hFF00_0000);

        // I-type addi x1,x1,1 must be rejected
        run_illegal("itype", 32'h0010_8093);
        read_reg("itype_x1", 5'd1, 32'd10);

        // add x0,x1,x2: completes, x0 stays 0
        run_rtype("x0", rt(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'd10, 32'd5, 32'd0);
        // preload to x0 is discarded
        preload(5'd0, 32'h1234_5678);
        read_reg("x0_pre", 5'd0, 32'd0);

`ifdef RTYPE_ISSUE_STRICT_EN
        run_illegal("strict", rt(7'h20, 5'd2, 5'd1, 3'd1, 5'd9));
        read_reg("strict_x9", 5'd9, 32'd0);
`else
        // funct7 passed through; ALU model does sll 10<<5
        run_rtype("loose", rt(7'h20, 5'd2, 5'd1, 3'd1, 5'd9), 32'd10, 32'd5, 32'd320);
`endif

        // collision: ext_we and instr_valid together
        ext_we = 1'b1; ext_addr = 5'd10; ext_data = 32'd7;
        instr = rt(7'h00, 5'd1, 5'd10, 3'd0, 5'd11); instr_valid = 1'b1;
        #1 chk("col_rdy0", 32'(instr_ready), 32'd0);
        @(negedge clk);
        ext_we = 1'b0;
        #1 chk("col_rdy1", 32'(instr_ready), 32'd1);
        read_reg("col_x10", 5'd10, 32'd7);
        run_rtype("col", rt(7'h00, 5'd1, 5'd10, 3'd0, 5'd11), 32'd7, 32'd10, 32'd17);

        // reset during EXEC aborts without writeback
        handshake(rt(7'h00, 5'd2, 5'd1, 3'd0, 5'd12));
        chk("ab_rs1_pre", rs1, 32'd10);
        reset_n = 1'b0;
        #1;
        chk("ab_rs1", rs1, 32'd0);
        chk("ab_rs2", rs2, 32'd0);
        chk("ab_f7", 32'(funct7), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        read_reg("ab_x1", 5'd1, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ab_done2", 32'(done), 32'd0);
        chk("ab_rdy", 32'(instr_ready), 32'd1);
        @(negedge clk);
        chk("ab_done3", 32'(done), 32'd0);
        read_reg("ab_x12", 5'd12, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
